// File: rtl/if_fetch_unit.sv
// IF stage: PC owner and instruction fetcher over a req/gnt/rvalid port.
// Buffers fetched words in a 2-entry FIFO and presents the head to IF/ID.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        InstrValid,
    output logic [31:0] Instruction_out,
    output logic [31:0] PCPlus4_out,
    output logic [31:0] PC_out
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_KILL
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_req_pc;
    logic [31:0] w_req_pc_nxt;
    logic [31:0] r_q_instr [2];
    logic [31:0] r_q_addr  [2];
    logic        r_rd;
    logic [1:0]  r_count;
    logic        w_push;
    logic        w_pop;
    logic        w_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_req_pc <= w_req_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_req_pc_nxt = r_req_pc;
        w_push       = 1'b0;
        imem_req     = (r_state == S_REQ) && (r_count != 2'd2)
                       && !PCSrc && !reset;
        unique case (r_state)
            S_REQ: begin
                if (PCSrc) begin
                    w_pc_nxt = BranchTarget;
                end else if (imem_req && imem_gnt) begin
                    w_req_pc_nxt = r_pc;
                    w_pc_nxt     = r_pc + 32'd4;
                    w_state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (PCSrc) begin
                    w_pc_nxt    = BranchTarget;
                    w_state_nxt = imem_rvalid ? S_REQ : S_KILL;
                end else if (imem_rvalid) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_KILL: begin
                // The killed response still has to drain before reissuing
                if (PCSrc) begin
                    w_pc_nxt = BranchTarget;
                end
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    assign imem_addr = r_pc;

    assign InstrValid      = (r_count != 2'd0) && !reset;
    assign Instruction_out = InstrValid ? r_q_instr[r_rd] : NOP_INSTR;
    assign PC_out          = InstrValid ? r_q_addr[r_rd] : 32'd0;
    assign PCPlus4_out     = InstrValid ? r_q_addr[r_rd] + 32'd4 : 32'd0;

    assign w_pop = InstrValid && !Stall && !PCSrc;
    assign w_wr  = r_rd ^ r_count[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 2'd0;
            r_rd    <= 1'b0;
        end else if (PCSrc) begin
            r_count <= 2'd0;
            r_rd    <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[w_wr] <= imem_rdata;
            r_q_addr[w_wr]  <= r_req_pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: random memory timing, stalls and redirects
// checked against an in-order address-stream model.
module tb_if_fetch_unit;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stall = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] BranchTarget = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        InstrValid;
    logic [31:0] Instruction_out;
    logic [31:0] PCPlus4_out;
    logic [31:0] PC_out;

    logic        req2;
    logic [31:0] addr2;
    logic        rv2 = 1'b0;
    logic [31:0] rd2 = 32'd0;
    logic        iv2;
    logic [31:0] ins2;
    logic [31:0] p42;
    logic [31:0] pc2;

    always #5 clk = ~clk;

    if_fetch_unit u_dut (
        .clk(clk), .reset(reset), .Stall(Stall), .PCSrc(PCSrc),
        .BranchTarget(BranchTarget),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .InstrValid(InstrValid), .Instruction_out(Instruction_out),
        .PCPlus4_out(PCPlus4_out), .PC_out(PC_out)
    );

    if_fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .reset(reset), .Stall(1'b0), .PCSrc(1'b0),
        .BranchTarget(32'd0),
        .imem_req(req2), .imem_addr(addr2),
        .imem_gnt(1'b1), .imem_rvalid(rv2),
        .imem_rdata(rd2),
        .InstrValid(iv2), .Instruction_out(ins2),
        .PCPlus4_out(p42), .PC_out(pc2)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // reference model: next address to be fetched / delivered
    logic [31:0] exp_fetch = 32'd0;
    logic [31:0] exp_pop = 32'd0;
    int          npop = 0;
    // memory model
    bit          outst = 1'b0;
    int          lat = 0;
    logic [31:0] oaddr = 32'd0;
    // previous-cycle observations
    bit          p_flush = 1'b0;
    bit          p_vhold = 1'b0;
    logic [31:0] p_pc = 32'd0;
    bit          p_reqhold = 1'b0;
    logic [31:0] p_addr = 32'd0;
    // wrap instance
    bit          p2 = 1'b0;
    logic [31:0] a2 = 32'd0;
    int          n2 = 0;
    int          f2 = 0;
    logic [31:0] wexp [3];

    task automatic cycle(input bit rst, input int st_pct, input int br_pct,
                         input int gnt_pct, input int lat_max);
        logic [7:0] t8;
        @(posedge clk);
        #1;
        reset       = rst;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (!rst && outst && lat == 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(oaddr);
        end
        Stall = ($urandom_range(1, 100) <= st_pct);
        PCSrc = !rst && ($urandom_range(1, 100) <= br_pct);
        t8 = 8'($urandom);
        if ($urandom_range(0, 15) == 0) begin
            BranchTarget = 32'hFFFF_FFF0;
        end else begin
            BranchTarget = {22'd0, t8, 2'b00};
        end
        rv2 = p2;
        rd2 = mem_word(a2);
        #1;
        imem_gnt = imem_req && ($urandom_range(1, 100) <= gnt_pct);
        #1;
        if (rst) begin
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_iv", {31'd0, InstrValid}, 32'd0);
            chk("rst_ins", Instruction_out, 32'd0);
            chk("rst_pc", PC_out, 32'd0);
            chk("rst_p4", PCPlus4_out, 32'd0);
            exp_fetch = 32'd0;
            exp_pop   = 32'd0;
            outst     = 1'b0;
            p_flush   = 1'b0;
            p_vhold   = 1'b0;
            p_reqhold = 1'b0;
            p2        = 1'b0;
        end else begin
            if (p_flush) begin
                chk("flush_iv", {31'd0, InstrValid}, 32'd0);
            end
            if (p_vhold) begin
                chk("hold_iv", {31'd0, InstrValid}, 32'd1);
                chk("hold_pc", PC_out, p_pc);
            end
            if (p_reqhold && !PCSrc) begin
                chk("req_hold", {31'd0, imem_req}, 32'd1);
                chk("addr_hold", imem_addr, p_addr);
            end
            if (!InstrValid) begin
                chk("idle_ins", Instruction_out, 32'd0);
            end
            if (PCSrc) begin
                chk("br_req", {31'd0, imem_req}, 32'd0);
                exp_fetch = BranchTarget;
                exp_pop   = BranchTarget;
            end else begin
                if (imem_req && imem_gnt) begin
                    chk("fetch", imem_addr, exp_fetch);
                    exp_fetch = exp_fetch + 32'd4;
                end
                if (InstrValid && !Stall) begin
                    chk("pop_pc", PC_out, exp_pop);
                    chk("pop_ins", Instruction_out, mem_word(exp_pop));
                    chk("pop_p4", PCPlus4_out, exp_pop + 32'd4);
                    exp_pop = exp_pop + 32'd4;
                    npop++;
                end
            end
            if (req2 && f2 < 3) begin
                chk("wrap_fetch", addr2, wexp[f2]);
                f2++;
            end
            if (iv2 && n2 < 3) begin
                chk("wrap_pc", pc2, wexp[n2]);
                chk("wrap_p4", p42, wexp[n2] + 32'd4);
                chk("wrap_ins", ins2, mem_word(wexp[n2]));
                n2++;
            end
            p_flush   = PCSrc;
            p_vhold   = InstrValid && Stall && !PCSrc;
            p_pc      = PC_out;
            p_reqhold = imem_req && !imem_gnt;
            p_addr    = imem_addr;
            if (imem_rvalid) begin
                outst = 1'b0;
            end else if (outst) begin
                lat--;
            end
            if (imem_req && imem_gnt) begin
                outst = 1'b1;
                oaddr = imem_addr;
                lat   = $urandom_range(1, lat_max);
            end
            p2 = req2;
            a2 = addr2;
        end
    endtask

    initial begin
        int base;
        wexp[0] = WRAP_PC;
        wexp[1] = 32'hFFFF_FFFC;
        wexp[2] = 32'h0000_0000;

        repeat (3) cycle(1'b1, 0, 0, 100, 1);

        npop = 0;
        repeat (40) cycle(1'b0, 0, 0, 100, 1);
        chk("thru", 32'(npop >= 18 && npop <= 20), 32'd1);
        chk("wrap_n", 32'(n2), 32'd3);

        repeat (8) cycle(1'b0, 100, 0, 100, 1);
        chk("stall_req", {31'd0, imem_req}, 32'd0);
        chk("stall_iv", {31'd0, InstrValid}, 32'd1);
        repeat (10) cycle(1'b0, 0, 0, 100, 1);

        repeat (6) cycle(1'b0, 0, 0, 0, 1);
        chk("starve_req", {31'd0, imem_req}, 32'd1);
        chk("starve_addr", imem_addr, exp_fetch);
        repeat (6) cycle(1'b0, 0, 0, 100, 1);

        base = npop;
        repeat (3000) cycle(1'b0, 30, 5, 60, 4);
        chk("live", 32'(npop > base + 100), 32'd1);

        repeat (2) cycle(1'b1, 0, 0, 100, 1);
        base = npop;
        repeat (20) cycle(1'b0, 0, 0, 100, 1);
        chk("rst_resume", 32'(npop >= 8), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
